pipelined_barrel_shifter: RTL
=============================

PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits; SHALL be a power of two, at least 8.
REQ-002 Parameter STAGES, default 2, number of register stages; SHALL be 1..$clog2(WIDTH).
REQ-003 Port CLK  input  1  the single clock; all state SHALL change on its rising edge.
REQ-004 Port nRST  input  1  asynchronous, active-low reset.
REQ-005 Port IN_VALID  input  1  the input operation is valid.
REQ-006 Port IN_READY  output  1  the block accepts an operation this cycle.
REQ-007 Port MODE  input  3  shift mode: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 PASS.
REQ-008 Port W  input  $clog2(WIDTH)  shift amount.
REQ-009 Port A  input  WIDTH  operand.
REQ-010 Port OUT_VALID  output  1  Y holds a valid result.
REQ-011 Port OUT_READY  input  1  downstream accepts the result.
REQ-012 Port Y  output  WIDTH  shift result.
REQ-013 Port Y_ZERO  output  1  high when Y equals 0, qualified by OUT_VALID.

Function
REQ-014 An operation SHALL transfer in on a rising edge where IN_VALID and IN_READY are both 1, and out where OUT_VALID and OUT_READY are both 1.
REQ-015 SLL/SRL SHALL shift by W with zero fill, SRA SHALL fill with A[WIDTH-1], ROL/ROR SHALL rotate by W, and PASS SHALL give Y=A.
REQ-016 W=0 SHALL give Y=A in every mode, and W SHALL never shift by WIDTH or more.
REQ-017 The $clog2(WIDTH) shift levels (level k shifts by 2^k when W[k]=1) SHALL be split across STAGES register stages, with no stage holding more than ceil($clog2(WIDTH)/STAGES) levels.
REQ-018 Each stage SHALL register its data, the remaining W bits, MODE and a valid bit.
REQ-019 Latency SHALL be exactly STAGES cycles from the accepting edge to OUT_VALID=1 when the pipeline is not stalled.
REQ-020 Throughput SHALL be one operation per cycle when OUT_READY=1.
REQ-021 Stage i SHALL advance when it is empty or stage i+1 advances; the last stage SHALL advance when OUT_VALID=0 or OUT_READY=1.
REQ-022 IN_READY SHALL equal the advance condition of stage 0, be combinational and never depend on IN_VALID.
REQ-023 Bubbles SHALL collapse, so a stalled output SHALL still let upstream empty stages fill.
REQ-024 Capacity SHALL be exactly STAGES operations; results SHALL emerge in acceptance order with none lost or duplicated.
REQ-025 While OUT_VALID=1 and OUT_READY=0, Y and Y_ZERO SHALL remain stable.
REQ-026 Simultaneous accept and emit on a full pipeline SHALL sustain throughput without a bubble.
REQ-027 Y_ZERO SHALL be derived from the registered last-stage data.

Reset
REQ-028 While nRST=0, all stage valid bits SHALL be 0, so OUT_VALID=0 and IN_READY=1, and Y and Y_ZERO SHALL be 0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight operations immediately, without waiting for CLK.
REQ-030 The first operation SHALL be accepted on the first rising edge after nRST deasserts.

Structure
REQ-031 The MODE encodings SHALL be localparams in a shared package, barrel_shifter_pkg, reused by later shifter/ALU blocks.
REQ-032 One combinational sub-module, barrel_shift_level (parameters WIDTH, SHIFT), SHALL implement one 2^k level for all modes and be instantiated $clog2(WIDTH) times.
REQ-033 No latches and no combinational path from IN_VALID to IN_READY SHALL exist.

Verification (WIDTH=32, STAGES=2 unless noted)
REQ-034 SLL, A=0x00000001, W=31 -> Y=0x80000000 with OUT_VALID exactly 2 cycles after acceptance.
REQ-035 A=0x80000000, W=4 -> SRA gives 0xF8000000, SRL gives 0x08000000, and ROR of A=0x000000F1, W=4 gives 0x1000000F.
REQ-036 With OUT_READY=0, three back-to-back inputs -> IN_READY drops after 2 accepts; after OUT_READY=1, results emerge in order with Y stable while stalled.
REQ-037 Asserting nRST low mid-stream with 2 operations in flight -> OUT_VALID=0 and Y=0 at once, and no stale result after release.
REQ-038 Random MODE/W/A with random OUT_READY, for STAGES in {1,3,5} -> every output matches a reference model, in order.
REQ-039 W=0 in all eight MODE codes with A=0xDEADBEEF -> Y=0xDEADBEEF, and A=0 -> Y_ZERO=1.

Source files
------------

// File: rtl/barrel_shifter_pkg.sv
// Shared shift-mode encodings and pipeline helpers for shifter/ALU blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package barrel_shifter_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_SLL = 3'b000;
  localparam logic [MODE_W-1:0] MODE_SRL = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SRA = 3'b010;
  localparam logic [MODE_W-1:0] MODE_ROL = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROR = 3'b100;
  // 101..111 all decode as pass-through.

  // Shift levels per register stage, rounded up so every level gets a home.
  function automatic int levels_per_stage(input int levels, input int stages);
    return (levels + stages - 1) / stages;
  endfunction

endpackage

// File: rtl/barrel_shift_level.sv
// One 2^k level of a barrel shifter, covering every shift/rotate mode.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
// Ports: en_i applies the SHIFT-bit move, mode_i selects the operation,
//        a_i is the operand, y_o the (possibly) shifted result.
module barrel_shift_level
  import barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHIFT = 1
) (
  input  logic              en_i,
  input  logic [MODE_W-1:0] mode_i,
  input  logic [WIDTH-1:0]  a_i,
  output logic [WIDTH-1:0]  y_o
);

  always_comb begin
    y_o = a_i;
    if (en_i) begin
      case (mode_i)
        MODE_SLL: y_o = a_i << SHIFT;
        MODE_SRL: y_o = a_i >> SHIFT;
        MODE_SRA: y_o = $signed(a_i) >>> SHIFT;
        MODE_ROL: y_o = {a_i[WIDTH-SHIFT-1:0], a_i[WIDTH-1:WIDTH-SHIFT]};
        MODE_ROR: y_o = {a_i[SHIFT-1:0], a_i[WIDTH-1:SHIFT]};
        default:  y_o = a_i;
      endcase
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Barrel shifter (SLL/SRL/SRA/ROL/ROR/PASS) split over STAGES register stages.
// Latency: STAGES cycles from acceptance to OUT_VALID; one op per cycle.
// Backpressure: valid/ready; stalled output holds, empty upstream stages still fill.
// Ports: CLK/nRST clock and async active-low reset; IN_VALID/IN_READY with
//        MODE, W (shift amount), A (operand) on the input side; OUT_VALID/
//        OUT_READY with Y (result) and Y_ZERO (Y==0 while valid) on the output.
module pipelined_barrel_shifter
  import barrel_shifter_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [MODE_W-1:0]        MODE,
  input  logic [$clog2(WIDTH)-1:0] W,
  input  logic [WIDTH-1:0]         A,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [WIDTH-1:0]         Y,
  output logic                     Y_ZERO
);

  localparam int AW   = $clog2(WIDTH);
  localparam int LVLS = AW;
  localparam int LPS  = levels_per_stage(LVLS, STAGES);

  // Per-stage registered state.
  logic [STAGES-1:0] vld_d, vld_q;
  logic [WIDTH-1:0]  dat_d  [STAGES];
  logic [WIDTH-1:0]  dat_q  [STAGES];
  logic [AW-1:0]     amt_d  [STAGES];
  logic [AW-1:0]     amt_q  [STAGES];
  logic [MODE_W-1:0] mode_d [STAGES];
  logic [MODE_W-1:0] mode_q [STAGES];

  // What feeds each stage's shift levels, and what those levels produce.
  logic [STAGES-1:0] stg_in_vld;
  logic [WIDTH-1:0]  stg_in_dat  [STAGES];
  logic [AW-1:0]     stg_in_amt  [STAGES];
  logic [MODE_W-1:0] stg_in_mode [STAGES];
  logic [WIDTH-1:0]  stg_shf_dat [STAGES];

  logic [STAGES-1:0] adv;

  // Level k lives in stage k/LPS. Each stage keeps the not-yet-applied amount
  // bits right-aligned, so level k reads bit (k mod LPS) of its stage's amount.
  for (genvar k = 0; k < LVLS; k++) begin : g_lvl
    localparam int S = k / LPS;
    localparam int J = k - S * LPS;
    logic [WIDTH-1:0] lvl_a;
    logic [WIDTH-1:0] lvl_y;

    if (J == 0) begin : g_head
      assign lvl_a = stg_in_dat[S];
    end else begin : g_chain
      assign lvl_a = g_lvl[k-1].lvl_y;
    end

    barrel_shift_level #(
      .WIDTH(WIDTH),
      .SHIFT(1 << k)
    ) u_level (
      .en_i  (stg_in_amt[S][J]),
      .mode_i(stg_in_mode[S]),
      .a_i   (lvl_a),
      .y_o   (lvl_y)
    );
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stg
    localparam int FIRST = s * LPS;
    localparam int LAST  = ((s + 1) * LPS < LVLS) ? ((s + 1) * LPS - 1) : (LVLS - 1);

    if (s == 0) begin : g_src
      assign stg_in_vld[s]  = IN_VALID;
      assign stg_in_dat[s]  = A;
      assign stg_in_amt[s]  = W;
      assign stg_in_mode[s] = MODE;
    end else begin : g_src
      assign stg_in_vld[s]  = vld_q[s-1];
      assign stg_in_dat[s]  = dat_q[s-1];
      assign stg_in_amt[s]  = amt_q[s-1];
      assign stg_in_mode[s] = mode_q[s-1];
    end

    // Trailing stages can end up with no levels when STAGES does not divide
    // the level count evenly; they are then plain pipeline registers.
    if (FIRST < LVLS) begin : g_shf
      assign stg_shf_dat[s] = g_lvl[LAST].lvl_y;
    end else begin : g_thru
      assign stg_shf_dat[s] = stg_in_dat[s];
    end
  end

  always_comb begin
    logic down_adv;
    down_adv = OUT_READY;
    adv      = '0;
    vld_d    = vld_q;
    // A stage advances when empty or when the stage after it advances, so
    // bubbles collapse and a full pipe can accept and emit in the same cycle.
    for (int s = STAGES - 1; s >= 0; s--) begin
      adv[s]   = !vld_q[s] || down_adv;
      down_adv = adv[s];
    end
    for (int s = 0; s < STAGES; s++) begin
      dat_d[s]  = dat_q[s];
      amt_d[s]  = amt_q[s];
      mode_d[s] = mode_q[s];
      if (adv[s]) begin
        vld_d[s] = stg_in_vld[s];
        // Payload only moves with a valid op, keeping Y quiet across bubbles.
        if (stg_in_vld[s]) begin
          dat_d[s]  = stg_shf_dat[s];
          amt_d[s]  = stg_in_amt[s] >> LPS;
          mode_d[s] = stg_in_mode[s];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      vld_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        dat_q[s]  <= '0;
        amt_q[s]  <= '0;
        mode_q[s] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int s = 0; s < STAGES; s++) begin
        dat_q[s]  <= dat_d[s];
        amt_q[s]  <= amt_d[s];
        mode_q[s] <= mode_d[s];
      end
    end
  end

  assign IN_READY  = adv[0];
  assign OUT_VALID = vld_q[STAGES-1];
  assign Y         = dat_q[STAGES-1];
  assign Y_ZERO    = vld_q[STAGES-1] && (dat_q[STAGES-1] == '0);

endmodule
